main_bus_arbiter: RTL and testbench

//  Shares the main bus between pipeline stage 2 (BusRequest control line) and N_EXT external masters (DMA, video).
//  - Pipeline has priority; external masters are served round-robin among themselves.
//  - Starvation limit on the pipeline guarantees external masters get the bus.
//  - Stall output holds pipeline stage 2 while the pipeline requests but is not granted.

---
 rtl/main_bus_pkg.sv | 35 +++
 rtl/main_bus_arbiter_rr_pick.sv | 39 +++
 rtl/main_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_main_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/main_bus_pkg.sv
// Shared types and constants for the main bus arbiter: FSM state encoding,
// bus-owner encoding, and counter widths.
package main_bus_pkg;

    localparam int STALL_CNT_W = 16;
    localparam int MAX_EXT     = 8;
    localparam int IDX_W       = 3;   // holds any external index 0..MAX_EXT-1
    localparam int CNT_W       = 8;   // burst / pipeline-run counters (limits up to 255)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PIPE = 2'd1,
        ST_EXT  = 2'd2,
        ST_TURN = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    // Which party holds the bus while the FSM sits in a given state.
    function automatic owner_e state_owner(input arb_state_e s);
        owner_e o;
        o = OWN_NONE;
        unique case (s)
            ST_PIPE: o = OWN_PIPE;
            ST_EXT:  o = OWN_EXT;
            default: o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/main_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first requester at or after
// the pointer, wrapping modulo N. Returns a one-hot grant, its index, and a
// valid flag.
module rr_pick
    import main_bus_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W:0] cand;

    // Scan offsets from the pointer; the first requesting candidate wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int off = 0; off < N; off++) begin
            cand = {1'b0, ptr_i} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            for (int i = 0; i < N; i++) begin
                if (!valid_o && req_i[i] && (cand == (IDX_W+1)'(i))) begin
                    valid_o  = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/main_bus_arbiter.sv
// Main bus arbiter: pipeline stage 2 has priority over N_EXT external
// masters, which are served round-robin. A pipeline run limit forces a
// turnaround to external masters; an external burst limit bounds ownership.
// One idle TURN cycle separates different owners.
// Optional build macro MAIN_BUS_ARB_STATS_EN enables the saturating
// pipeline stall-cycle counter; without it StallCount is tied to zero.
//
// state | meaning
// IDLE  | nobody owns the bus, nothing pending last cycle
// PIPE  | pipeline stage 2 owns the bus
// EXT   | one external master owns the bus (one-hot ExtGrant)
// TURN  | single dead cycle between different owners
module main_bus_arbiter
    import main_bus_pkg::*;
#(
    parameter int N_EXT        = 2,
    parameter int BURST_MAX    = 16,
    parameter int PIPE_RUN_MAX = 8
) (
    input  logic                   ClockIn,
    input  logic                   Reset,
    input  logic                   PipeReq,
    output logic                   PipeGrant,
    output logic                   PipeStall,
    input  logic [N_EXT-1:0]       ExtReq,
    input  logic [N_EXT-1:0]       ExtDone,
    output logic [N_EXT-1:0]       ExtGrant,
    output logic [STALL_CNT_W-1:0] StallCount
);

    arb_state_e       state_q, state_d;
    logic             pipe_grant_q, pipe_grant_d;
    logic [N_EXT-1:0] ext_grant_q, ext_grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             forced_q, forced_d;

    logic [N_EXT-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    logic             any_ext;
    logic             owner_done;
    logic             owner_req;
    logic             other_ext;
    logic             ext_release;
    logic [CNT_W-1:0] run_cnt_next;
    logic             go_pipe;
    logic             go_ext;

    rr_pick #(.N(N_EXT)) u_rr_pick (
        .req_i   (ExtReq),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign any_ext      = |ExtReq;
    // ext_grant_q doubles as the owner mask, so non-owner ExtDone is masked off.
    assign owner_done   = |(ExtDone & ext_grant_q);
    assign owner_req    = |(ExtReq & ext_grant_q);
    assign other_ext    = |(ExtReq & ~ext_grant_q);
    assign ext_release  = owner_done || !owner_req || (burst_cnt_q == CNT_W'(BURST_MAX));
    assign run_cnt_next = run_cnt_q + CNT_W'(1);

    // Next-state, next-grant and counter updates.
    always_comb begin
        state_d     = state_q;
        ext_grant_d = '0;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = '0;
        run_cnt_d   = '0;
        forced_d    = 1'b0;
        go_pipe     = 1'b0;
        go_ext      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (PipeReq) begin
                    go_pipe = 1'b1;
                end else if (pick_valid) begin
                    go_ext = 1'b1;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                // A forced pipeline release hands the bus to an external master
                // even though the pipeline is still asking for it.
                if (forced_q && pick_valid) begin
                    go_ext = 1'b1;
                end else if (PipeReq) begin
                    go_pipe = 1'b1;
                end else if (pick_valid) begin
                    go_ext = 1'b1;
                end
            end
            ST_PIPE: begin
                if (!PipeReq) begin
                    state_d = any_ext ? ST_TURN : ST_IDLE;
                end else if (any_ext && (run_cnt_next == CNT_W'(PIPE_RUN_MAX))) begin
                    state_d  = ST_TURN;
                    forced_d = 1'b1;
                end else begin
                    run_cnt_d = any_ext ? run_cnt_next : '0;
                end
            end
            ST_EXT: begin
                if (ext_release) begin
                    state_d = (PipeReq || other_ext) ? ST_TURN : ST_IDLE;
                end else begin
                    ext_grant_d = ext_grant_q;
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_pipe) begin
            state_d = ST_PIPE;
        end
        if (go_ext) begin
            state_d     = ST_EXT;
            ext_grant_d = pick_gnt;
            burst_cnt_d = CNT_W'(1);
            rr_ptr_d    = (pick_idx == IDX_W'(N_EXT-1)) ? '0 : pick_idx + IDX_W'(1);
        end

        pipe_grant_d = (state_owner(state_d) == OWN_PIPE);
    end

    // State and grant registers; reset overrides every other event.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            pipe_grant_q <= 1'b0;
            ext_grant_q  <= '0;
            rr_ptr_q     <= '0;
            burst_cnt_q  <= '0;
            run_cnt_q    <= '0;
            forced_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pipe_grant_q <= pipe_grant_d;
            ext_grant_q  <= ext_grant_d;
            rr_ptr_q     <= rr_ptr_d;
            burst_cnt_q  <= burst_cnt_d;
            run_cnt_q    <= run_cnt_d;
            forced_q     <= forced_d;
        end
    end

    assign PipeGrant = pipe_grant_q;
    assign ExtGrant  = ext_grant_q;
    assign PipeStall = PipeReq & ~pipe_grant_q;

`ifdef MAIN_BUS_ARB_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles the pipeline spent stalled.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else if (PipeStall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Bench for main_bus_arbiter: directed scenarios followed by a randomized run,
// every cycle compared against an ownership-level reference model.
module tb_main_bus_arbiter;

    localparam int N_EXT        = 2;
    localparam int BURST_MAX    = 16;
    localparam int PIPE_RUN_MAX = 8;
    localparam int PIPE_ID      = 100;
    localparam int NOBODY       = -1;

    logic             ClockIn = 1'b0;
    logic             Reset   = 1'b1;
    logic             PipeReq = 1'b0;
    logic [N_EXT-1:0] ExtReq  = '0;
    logic [N_EXT-1:0] ExtDone = '0;
    logic             PipeGrant;
    logic             PipeStall;
    logic [N_EXT-1:0] ExtGrant;
    logic [15:0]      StallCount;

    always #5 ClockIn = ~ClockIn;

    main_bus_arbiter #(
        .N_EXT        (N_EXT),
        .BURST_MAX    (BURST_MAX),
        .PIPE_RUN_MAX (PIPE_RUN_MAX)
    ) dut (
        .ClockIn    (ClockIn),
        .Reset      (Reset),
        .PipeReq    (PipeReq),
        .PipeGrant  (PipeGrant),
        .PipeStall  (PipeStall),
        .ExtReq     (ExtReq),
        .ExtDone    (ExtDone),
        .ExtGrant   (ExtGrant),
        .StallCount (StallCount)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, whether a turnaround is due, and
    // the counters the rules refer to.
    int m_owner  = NOBODY;
    bit m_turn   = 1'b0;
    bit m_forced = 1'b0;
    int m_ptr    = 0;
    int m_burst  = 0;
    int m_run    = 0;
    int m_stalls = 0;

    function automatic int rr_first(input int reqv, input int ptr);
        for (int off = 0; off < N_EXT; off++) begin
            int c = (ptr + off) % N_EXT;
            if (((reqv >> c) & 1) != 0) return c;
        end
        return NOBODY;
    endfunction

    task automatic model_step();
        int reqv;
        int donev;
        int mine;
        bit any_ext;
        bit ext_first;
        reqv    = int'(ExtReq);
        donev   = int'(ExtDone);
        any_ext = (reqv != 0);
        if (Reset) begin
            m_owner = NOBODY; m_turn = 0; m_forced = 0;
            m_ptr = 0; m_burst = 0; m_run = 0; m_stalls = 0;
            return;
        end
`ifdef MAIN_BUS_ARB_STATS_EN
        if (PipeReq && (m_owner != PIPE_ID) && (m_stalls < 65535)) m_stalls++;
`endif
        if (m_owner == NOBODY) begin
            ext_first = m_turn && m_forced && any_ext;
            m_turn    = 0;
            m_forced  = 0;
            if (!ext_first && PipeReq) begin
                m_owner = PIPE_ID;
                m_run   = 0;
            end else if (any_ext) begin
                m_owner = rr_first(reqv, m_ptr);
                m_ptr   = (m_owner + 1) % N_EXT;
                m_burst = 1;
            end
        end else if (m_owner == PIPE_ID) begin
            if (!PipeReq) begin
                m_owner = NOBODY;
                m_turn  = any_ext;
                m_run   = 0;
            end else if (any_ext) begin
                m_run++;
                if (m_run == PIPE_RUN_MAX) begin
                    m_owner  = NOBODY;
                    m_turn   = 1;
                    m_forced = 1;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            mine = 1 << m_owner;
            if (((donev & mine) != 0) || ((reqv & mine) == 0) || (m_burst == BURST_MAX)) begin
                m_turn  = PipeReq || ((reqv & ~mine) != 0);
                m_owner = NOBODY;
                m_burst = 0;
            end else begin
                m_burst++;
            end
        end
    endtask

    // Advance one clock with the current inputs and compare all outputs.
    task automatic cycle();
        int exp_eg;
        bit exp_pg;
        model_step();
        @(posedge ClockIn);
        #1;
        exp_pg = (m_owner == PIPE_ID);
        exp_eg = (m_owner >= 0 && m_owner < N_EXT) ? (1 << m_owner) : 0;
        check("pipe_grant", PipeGrant, exp_pg);
        check("ext_grant", ExtGrant, exp_eg);
        check("pipe_stall", PipeStall, PipeReq && !exp_pg);
        check("stall_count", StallCount, m_stalls);
    endtask

    task automatic reset_dut();
        Reset = 1'b1; PipeReq = 1'b0; ExtReq = '0; ExtDone = '0;
        cycle();
        Reset = 1'b0;
    endtask

    int n;

    initial begin
        // Reset held with everything requesting: nothing may be granted.
        Reset = 1'b1; PipeReq = 1'b1; ExtReq = 2'b11; ExtDone = '0;
        repeat (3) cycle();
        check("t1_rst_pipe", PipeGrant, 0);
        check("t1_rst_ext", ExtGrant, 0);
        check("t1_rst_stats", StallCount, 0);
        // Reset dropped just after the last reset edge; grant on the next edge.
        Reset = 1'b0;
        cycle();
        check("t1_release_grant", PipeGrant, 1);

        // Turnaround after ExtDone with the pipeline waiting.
        reset_dut();
        ExtReq = 2'b01;
        cycle();
        check("t2_ext0_owns", ExtGrant, 2'b01);
        repeat (8) cycle();
        PipeReq = 1'b1; ExtDone = 2'b01;
        #1 check("t2_stall_done_cycle", PipeStall, 1);
        cycle();
        ExtDone = '0;
        check("t2_turn_no_ext", ExtGrant, 0);
        check("t2_turn_no_pipe", PipeGrant, 0);
        #1 check("t2_stall_turn_cycle", PipeStall, 1);
        cycle();
        check("t2_pipe_granted", PipeGrant, 1);

        // Pipeline starvation limit.
        reset_dut();
        PipeReq = 1'b1;
        cycle();
        check("t3_pipe_owns", PipeGrant, 1);
        ExtReq = 2'b10;
        n = 0;
        while (PipeGrant && n < 20) begin
            n++;
            cycle();
        end
        check("t3_pipe_run_len", n, PIPE_RUN_MAX);
        check("t3_turn", ExtGrant, 0);
        cycle();
        check("t3_ext1_after_turn", ExtGrant, 2'b10);

        // External burst limit.
        reset_dut();
        ExtReq = 2'b01;
        cycle();
        ExtReq = 2'b11;
        n = 0;
        while (ExtGrant == 2'b01 && n < 40) begin
            n++;
            cycle();
        end
        check("t4_burst_len", n, BURST_MAX);
        check("t4_turn", ExtGrant, 0);
        cycle();
        check("t4_ext1_next", ExtGrant, 2'b10);

        // Round-robin alternation with a bogus ExtDone from the non-owner.
        reset_dut();
        ExtReq = 2'b11;
        cycle();
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
            check("t5_rr_grant", ExtGrant, exp_g);
            if (exp_g == 2'b01) begin
                ExtDone = 2'b10;
                cycle();
                ExtDone = '0;
                check("t5_bogus_done_ignored", ExtGrant, 2'b01);
            end
            ExtDone = exp_g;
            cycle();
            ExtDone = '0;
            check("t5_turn_between", ExtGrant, 0);
            cycle();
        end

        // Stall statistics: five stalled cycles behind an external burst.
        reset_dut();
        ExtReq = 2'b01;
        cycle();
        PipeReq = 1'b1;
        repeat (5) cycle();
`ifdef MAIN_BUS_ARB_STATS_EN
        check("t6_stall_count", StallCount, 5);
`else
        check("t6_stall_count_off", StallCount, 0);
`endif

        // Randomized traffic including mid-burst resets and stray ExtDone.
        reset_dut();
        for (int c = 0; c < 4000; c++) begin
            Reset = ($urandom_range(199) == 0);
            if ($urandom_range(5) == 0) PipeReq = ~PipeReq;
            for (int b = 0; b < N_EXT; b++) begin
                if ($urandom_range(7) == 0) ExtReq[b] = ~ExtReq[b];
                ExtDone[b] = ($urandom_range(5) == 0);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
